majority_voter_seq: RTL and testbench
=====================================

Name: majority_voter_seq

Overview:
- Registered, parametrised N-channel, W-bit bitwise majority voter with valid handshake and per-channel health tracking. Generalises the 3-input single-bit majority gate.
- Each output bit is 1 when more than half of the channels drive 1 on that bit.
- Per-channel saturating mismatch counters mark a channel as faulty after FAULT_LIMIT consecutive disagreements.
- Sits between redundant (TMR/NMR) datapath replicas and downstream logic.

Parameters:
- N, 3: channel count; odd, >=3.
- W, 1: data width per channel; >=1.
- FAULT_LIMIT, 4: consecutive disagreeing valid samples before a channel is marked faulty; >=1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data qualifies this cycle.
- in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
- clear_faults  input  1  synchronous clear of fault flags and counters.
- out_valid  output  1  out_data, disagree and unanimous qualify this cycle.
- out_data  output  W  voted word.
- disagree  output  N  bit i = channel i's word differed from the vote.
- unanimous  output  1  all channels equal the vote.
- fault  output  N  sticky per-channel fault flag.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs are forced to 0 immediately, and all counters are 0.
- Reset is asynchronous assert, synchronous deassert at the next clk edge. The first sample may be accepted at that edge.
- Vote: for each bit b, compute ones(b) = count of channels with bit b = 1. The vote is 1 iff 2*ones(b) > N. Use a popcount of width clog2(N+1); no overflow is possible.
- Latency is 1 cycle. When in_valid=1 at edge k:
  - out_valid=1 after edge k, together with out_data, disagree and unanimous for that sample.
  - When in_valid=0, out_valid=0 after the edge; out_data, disagree and unanimous hold their previous values.
- No backpressure: every valid sample is accepted. Back-to-back valid inputs give back-to-back outputs.
- disagree[i] = (channel i word != voted word), comparing the whole word.
- unanimous = ~|disagree, computed for the same sample.
- Counter cnt[i] has width clog2(FAULT_LIMIT+1) and updates only on edges with in_valid=1:
  - Channel disagrees: cnt[i] increments, saturating at FAULT_LIMIT.
  - Channel agrees: cnt[i] = 0.
- Fault set: fault[i] is set at the edge where cnt[i] reaches FAULT_LIMIT. It is visible in the same cycle as the out_valid of the FAULT_LIMIT-th consecutive disagreeing sample.
- Fault hold: fault[i] stays set regardless of later agreement, until clear_faults or reset.
- clear_faults=1 at an edge:
  - Clears all fault and cnt to 0.
  - Takes priority over a simultaneous fault set or counter increment.
  - A valid sample in the same cycle still produces out_data, disagree and unanimous normally.
- Idle cycles (in_valid=0) do not break a consecutive-disagreement run; counters hold.

Optional Feature:
- Macro: MAJORITY_FAULT_MASK_EN.
- Defined:
  - Channels with fault[i]=1 are excluded from the vote. Let A = number of unmasked channels.
  - Vote bit is 1 iff 2*ones(b) > A, and 0 iff 2*ones(b) < A.
  - Tie (2*ones(b) == A) outputs the previous out_data bit.
  - A=0: out_data holds, disagree is all 0, and unanimous=0.
  - Masked channels still report disagree and still count, but cannot re-fault until cleared.
- Undefined: fault is status only and every channel votes.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, fault=0 immediately, before any clk edge.
- Exhaustive N=3, W=1: apply all 8 input combinations (000..111) with in_valid=1 -> out_data one cycle later = 0,0,0,1,0,1,1,1. unanimous=1 only for 000 and 111.
- N=3, W=4, channels {0xA, 0xA, 0x5} -> out_data=0xA, disagree=3'b100, unanimous=0.
- N=3, W=4, channels {0x3, 0x5, 0x6} -> out_data=0x7, disagree=3'b111.
- Fault with FAULT_LIMIT=4:
  - Channel 2 disagrees on 4 valid samples with in_valid gaps between them -> fault=3'b100 with the 4th output.
  - 3 disagreements then 1 agreement -> fault stays 0.
- clear_faults asserted on the same edge as the 4th disagreement -> fault=0, cnt=0.
- With MAJORITY_FAULT_MASK_EN, N=3, channel 2 faulty:
  - {0xF, 0x0, x} -> tie, so out_data holds its previous value.
  - {0x9, 0x9, 0x6} -> out_data=0x9.

Source files
------------

// File: rtl/majority_voter_seq.sv
// Registered N-channel, W-bit bitwise majority voter with per-channel disagreement tracking.
// Define MAJORITY_FAULT_MASK_EN to drop faulty channels from the vote (ties hold the last vote).
module majority_voter_seq #(
  parameter int unsigned N           = 3,
  parameter int unsigned W           = 1,
  parameter int unsigned FAULT_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic           clear_faults,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   disagree,
  output logic           unanimous,
  output logic [N-1:0]   fault
);

  localparam int unsigned PW = $clog2(N + 1);
  localparam int unsigned CW = $clog2(FAULT_LIMIT + 1);
  localparam logic [CW-1:0] Limit = CW'(FAULT_LIMIT);
  localparam logic [PW:0]   NumCh = (PW + 1)'(N);

  logic [W-1:0]  chan [N];
  logic [N-1:0]  mask;
  logic [PW-1:0] active;
  logic [PW-1:0] ones [W];
  logic          all_masked;
  logic [W-1:0]  vote;
  logic [N-1:0]  dis;
  logic          unan;

  logic           out_valid_q;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [N-1:0]   disagree_q, disagree_d;
  logic           unanimous_q, unanimous_d;
  logic [N-1:0]   fault_q, fault_d;
  logic [CW-1:0]  cnt_q [N];
  logic [CW-1:0]  cnt_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      chan[i] = in_data[i*W +: W];
    end
  end

  always_comb begin
`ifdef MAJORITY_FAULT_MASK_EN
    mask = fault_q;
`else
    mask = '0;
`endif
    active = '0;
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) active = active + PW'(1);
    end
    all_masked = (active == '0);
  end

  // Per-bit popcount over the voting channels.
  always_comb begin
    for (int b = 0; b < W; b++) begin
      ones[b] = '0;
      for (int i = 0; i < N; i++) begin
        if (chan[i][b] && !mask[i]) ones[b] = ones[b] + PW'(1);
      end
    end
  end

  always_comb begin
    vote = '0;
    for (int b = 0; b < W; b++) begin
`ifdef MAJORITY_FAULT_MASK_EN
      // A tie (including no voters at all) keeps the previous voted bit.
      if ({ones[b], 1'b0} > {1'b0, active}) begin
        vote[b] = 1'b1;
      end else if ({ones[b], 1'b0} < {1'b0, active}) begin
        vote[b] = 1'b0;
      end else begin
        vote[b] = out_data_q[b];
      end
`else
      vote[b] = ({ones[b], 1'b0} > NumCh);
`endif
    end
  end

  always_comb begin
    dis = '0;
    for (int i = 0; i < N; i++) begin
      dis[i] = (chan[i] != vote) && !all_masked;
    end
    unan = ~|dis && !all_masked;
  end

  always_comb begin
    out_data_d  = out_data_q;
    disagree_d  = disagree_q;
    unanimous_d = unanimous_q;
    if (in_valid) begin
      out_data_d  = vote;
      disagree_d  = dis;
      unanimous_d = unan;
    end
  end

  // Counters track consecutive disagreeing valid samples; idle cycles leave them untouched.
  always_comb begin
    fault_d = fault_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (clear_faults) begin
      fault_d = '0;
      for (int i = 0; i < N; i++) begin
        cnt_d[i] = '0;
      end
    end else if (in_valid) begin
      for (int i = 0; i < N; i++) begin
        if (dis[i]) begin
          if (cnt_q[i] != Limit) cnt_d[i] = cnt_q[i] + CW'(1);
        end else begin
          cnt_d[i] = '0;
        end
        if (cnt_d[i] == Limit) fault_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      disagree_q  <= '0;
      unanimous_q <= 1'b0;
      fault_q     <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_valid_q <= in_valid;
      out_data_q  <= out_data_d;
      disagree_q  <= disagree_d;
      unanimous_q <= unanimous_d;
      fault_q     <= fault_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign disagree  = disagree_q;
  assign unanimous = unanimous_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_majority_voter_seq.sv
// Bench for majority_voter_seq: vector table, hand-written fault sequences and a randomized run
// checked against a counting model of the voter.
module tb_majority_voter_seq;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 4;
  localparam int unsigned FL = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [N*W-1:0] in_data;
  logic           clear_faults;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [N-1:0]   disagree;
  logic           unanimous;
  logic [N-1:0]   fault;

  majority_voter_seq #(
    .N           (N),
    .W           (W),
    .FAULT_LIMIT (FL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .clear_faults (clear_faults),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .disagree     (disagree),
    .unanimous    (unanimous),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N*W-1:0] data;
    logic [W-1:0]   out;
    logic [N-1:0]   dis;
    logic           un;
  } vec_t;

  vec_t tbl [10];

  // Reference model state
  logic [W-1:0] m_out;
  logic [N-1:0] m_dis;
  logic [N-1:0] m_flt;
  logic         m_un;
  logic         m_valid;
  int           run [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dis = '0; m_flt = '0; m_un = 1'b0; m_valid = 1'b0;
    for (int i = 0; i < N; i++) run[i] = 0;
  endtask

  task automatic model_step(input logic v, input logic [N*W-1:0] d, input logic c);
    int           act;
    int           cnt1;
    logic [W-1:0] vt;
    logic [N-1:0] msk;
    logic [W-1:0] word;
    if (v) begin
`ifdef MAJORITY_FAULT_MASK_EN
      msk = m_flt;
`else
      msk = '0;
`endif
      act = N - $countones(msk);
      for (int b = 0; b < W; b++) begin
        cnt1 = 0;
        for (int i = 0; i < N; i++) if (!msk[i] && d[i*W+b]) cnt1++;
        if (2 * cnt1 > act)      vt[b] = 1'b1;
        else if (2 * cnt1 < act) vt[b] = 1'b0;
        else                     vt[b] = m_out[b];
      end
      for (int i = 0; i < N; i++) begin
        word = d[i*W +: W];
        m_dis[i] = (act > 0) && (word != vt);
      end
      m_un  = (act > 0) && (m_dis == '0);
      m_out = vt;
      for (int i = 0; i < N; i++) begin
        run[i] = m_dis[i] ? run[i] + 1 : 0;
        if (run[i] >= FL) m_flt[i] = 1'b1;
      end
    end
    m_valid = v;
    if (c) begin
      m_flt = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [N*W-1:0] d, input logic c);
    @(negedge clk);
    in_valid     = v;
    in_data      = d;
    clear_faults = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "_data"},  32'(out_data),  32'(m_out));
    chk({tag, "_dis"},   32'(disagree),  32'(m_dis));
    chk({tag, "_unan"},  32'(unanimous), 32'(m_un));
    chk({tag, "_fault"}, 32'(fault),     32'(m_flt));
  endtask

  logic [N*W-1:0] rd;
  logic [W-1:0]   base;
  int             mode;

  initial begin
    // Exhaustive single-bit combinations on bit 0 of each channel, then two wide words.
    tbl[0] = '{12'h000, 4'h0, 3'b000, 1'b1};
    tbl[1] = '{12'h001, 4'h0, 3'b001, 1'b0};
    tbl[2] = '{12'h010, 4'h0, 3'b010, 1'b0};
    tbl[3] = '{12'h011, 4'h1, 3'b100, 1'b0};
    tbl[4] = '{12'h100, 4'h0, 3'b100, 1'b0};
    tbl[5] = '{12'h101, 4'h1, 3'b010, 1'b0};
    tbl[6] = '{12'h110, 4'h1, 3'b001, 1'b0};
    tbl[7] = '{12'h111, 4'h1, 3'b000, 1'b1};
    tbl[8] = '{12'h5AA, 4'hA, 3'b100, 1'b0};
    tbl[9] = '{12'h653, 4'h7, 3'b111, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear_faults = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_dis",   32'(disagree),  32'd0);
    chk("rst_unan",  32'(unanimous), 32'd0);
    chk("rst_fault", 32'(fault),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      drive(1'b1, tbl[k].data, 1'b0);
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_data",  32'(out_data),  32'(tbl[k].out));
      chk("tbl_dis",   32'(disagree),  32'(tbl[k].dis));
      chk("tbl_unan",  32'(unanimous), 32'(tbl[k].un));
    end

    // Idle cycle: valid drops, data holds.
    drive(1'b0, 12'h111, 1'b0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_hold",  32'(out_data),  32'h7);

    // Channel 2 disagrees four times with idle gaps.
    drive(1'b0, 12'h000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 12'h500, 1'b0);
      chk("f4_dis", 32'(disagree), 32'b100);
      chk("f4_fault", 32'(fault), (k == 3) ? 32'b100 : 32'b000);
      drive(1'b0, 12'h000, 1'b0);
      drive(1'b0, 12'h000, 1'b0);
    end
    chk("f4_sticky", 32'(fault), 32'b100);

`ifdef MAJORITY_FAULT_MASK_EN
    drive(1'b1, 12'h699, 1'b0);
    chk("mask_data", 32'(out_data), 32'h9);
    chk("mask_dis",  32'(disagree), 32'b100);
    drive(1'b1, 12'h30F, 1'b0);
    chk("mask_tie",      32'(out_data),  32'h9);
    chk("mask_tie_dis",  32'(disagree),  32'b111);
    chk("mask_tie_unan", 32'(unanimous), 32'd0);
`endif

    // Three disagreements then one agreement restart the run.
    drive(1'b0, 12'h000, 1'b1);
    chk("clr_fault", 32'(fault), 32'd0);
    for (int k = 0; k < 3; k++) drive(1'b1, 12'h500, 1'b0);
    drive(1'b1, 12'h000, 1'b0);
    chk("agree_fault", 32'(fault), 32'd0);
    for (int k = 0; k < 3; k++) drive(1'b1, 12'h500, 1'b0);
    chk("rerun_fault", 32'(fault), 32'd0);

    // clear_faults coincident with the fourth disagreement wins.
    drive(1'b0, 12'h000, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, 12'h500, 1'b0);
    drive(1'b1, 12'h500, 1'b1);
    chk("cc_fault", 32'(fault),     32'd0);
    chk("cc_valid", 32'(out_valid), 32'd1);
    chk("cc_dis",   32'(disagree),  32'b100);
    chk("cc_data",  32'(out_data),  32'h0);
    for (int k = 0; k < 3; k++) drive(1'b1, 12'h500, 1'b0);
    chk("cc_cnt0", 32'(fault), 32'd0);
    drive(1'b1, 12'h500, 1'b0);
    chk("cc_refault", 32'(fault), 32'b100);

    // Randomized run against the model.
    drive(1'b0, 12'h000, 1'b1);
    for (int k = 0; k < 400; k++) begin
      base = W'($urandom);
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) rd[i*W +: W] = base;
      if (mode == 0) rd = (N*W)'($urandom);
      else if (mode != 3) rd[(N-1)*W +: W] = W'($urandom);
      drive(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 15) == 0));
      check_model("rnd");
    end

    // Asynchronous reset mid-stream with live outputs and a fault set.
    drive(1'b0, 12'h000, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b1, 12'h500, 1'b0);
    drive(1'b1, 12'h5AA, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_data",  32'(out_data),  32'hA);
    chk("pre_rst_fault", 32'(fault),     32'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data",  32'(out_data),  32'd0);
    chk("arst_fault", 32'(fault),     32'd0);
    chk("arst_dis",   32'(disagree),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
